// File: rtl/shift_fifo_ctrl.sv
// Control for a shift-register FIFO: new words enter storage location 0, index tracks the oldest word.
// Push-to-out_valid is two cycles (one SETTLE cycle per push or pop); pushes are dropped while full.
module shift_fifo_ctrl #(
    parameter int BIT_WIDTH  = 16,
    parameter int NUM_WORDS  = 64,
    parameter int ADDR_WIDTH = 6
) (
    input  logic                  write_clk,
    input  logic                  fifo_reset,
    input  logic [BIT_WIDTH-1:0]  in_data,
    input  logic                  in_valid,
    output logic                  in_ready,
    input  logic                  pop,
    output logic                  out_valid,
    output logic [BIT_WIDTH-1:0]  write_data,
    output logic                  write_en,
    output logic [ADDR_WIDTH-1:0] index,
    output logic [ADDR_WIDTH:0]   count,
    output logic                  full,
    output logic                  empty,
    output logic                  underflow_err
);

    typedef enum logic [1:0] {
        ST_EMPTY,
        ST_SETTLE,
        ST_READY
    } state_t;

    localparam logic [ADDR_WIDTH:0] FULL_CNT = (ADDR_WIDTH + 1)'(NUM_WORDS);

    state_t                state_q, state_d;
    logic [ADDR_WIDTH:0]   count_q, count_d;
    logic [ADDR_WIDTH-1:0] index_q, index_d;
    logic                  underflow_q, underflow_d;
    logic                  push, pop_ok;

    assign full          = (count_q == FULL_CNT);
    assign empty         = (count_q == '0);
    assign count         = count_q;
    assign index         = index_q;
    assign underflow_err = underflow_q;
    assign out_valid     = (state_q == ST_READY);
    assign in_ready      = !full && !fifo_reset;
    assign push          = in_valid && in_ready;
    assign pop_ok        = pop && out_valid;
    assign write_en      = push;
    assign write_data    = in_data;

    always_comb begin
        count_d     = count_q;
        state_d     = state_q;
        underflow_d = underflow_q | (pop && !out_valid);

        if (push && !pop_ok) begin
            count_d = count_q + 1'b1;
        end else if (pop_ok && !push) begin
            count_d = count_q - 1'b1;
        end

        // Storage shifts toward higher addresses, so the oldest word always sits at count-1.
        index_d = (count_d != '0) ? ADDR_WIDTH'(count_d - 1'b1) : '0;

        case (state_q)
            ST_EMPTY: begin
                if (push) state_d = ST_SETTLE;
            end
            ST_SETTLE: begin
                state_d = push ? ST_SETTLE : ST_READY;
            end
            ST_READY: begin
                if (push) begin
                    state_d = ST_SETTLE;
                end else if (pop_ok) begin
                    state_d = (count_d == '0) ? ST_EMPTY : ST_SETTLE;
                end
            end
            default: state_d = ST_EMPTY;
        endcase
    end

    always_ff @(posedge write_clk) begin
        if (fifo_reset) begin
            state_q     <= ST_EMPTY;
            count_q     <= '0;
            index_q     <= '0;
            underflow_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            count_q     <= count_d;
            index_q     <= index_d;
            underflow_q <= underflow_d;
        end
    end

endmodule

// File: tb/tb_shift_fifo_ctrl.sv
// Bench for shift_fifo_ctrl: directed scenarios plus random traffic against a queue reference model.
// Includes a behavioural shift-register storage so read_data can be checked whenever out_valid is high.
module tb_shift_fifo_ctrl;

    localparam int BW    = 16;
    localparam int DEPTH = 64;
    localparam int AW    = 6;

    logic          write_clk = 1'b0;
    logic          fifo_reset;
    logic [BW-1:0] in_data;
    logic          in_valid;
    logic          in_ready;
    logic          pop;
    logic          out_valid;
    logic [BW-1:0] write_data;
    logic          write_en;
    logic [AW-1:0] index;
    logic [AW:0]   count;
    logic          full;
    logic          empty;
    logic          underflow_err;

    shift_fifo_ctrl #(.BIT_WIDTH(BW), .NUM_WORDS(DEPTH), .ADDR_WIDTH(AW)) dut (
        .write_clk     (write_clk),
        .fifo_reset    (fifo_reset),
        .in_data       (in_data),
        .in_valid      (in_valid),
        .in_ready      (in_ready),
        .pop           (pop),
        .out_valid     (out_valid),
        .write_data    (write_data),
        .write_en      (write_en),
        .index         (index),
        .count         (count),
        .full          (full),
        .empty         (empty),
        .underflow_err (underflow_err)
    );

    always #5 write_clk = ~write_clk;

    // Downstream storage: shift in at location 0, registered read of mem[index].
    logic [BW-1:0] mem [DEPTH];
    logic [BW-1:0] read_data;

    always @(posedge write_clk) begin
        read_data <= mem[index];
        if (write_en) begin
            for (int i = DEPTH - 1; i > 0; i--) mem[i] <= mem[i-1];
            mem[0] <= write_data;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=0x%0h exp=0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: words held oldest-first, plus the visible-output flag.
    logic [BW-1:0] model_q[$];
    logic          m_valid = 1'b0;
    logic          m_uflow = 1'b0;
    logic [BW-1:0] popped_q[$];

    task automatic cycle(input logic v, input logic [BW-1:0] d, input logic p, input logic r);
        logic exp_rdy, exp_push, honored;
        @(negedge write_clk);
        in_valid   = v;
        in_data    = d;
        pop        = p;
        fifo_reset = r;
        #1;
        exp_rdy  = !r && (model_q.size() < DEPTH);
        exp_push = v && exp_rdy;
        honored  = p && m_valid && !r;
        chk("in_ready", 32'(in_ready), 32'(exp_rdy));
        chk("write_en", 32'(write_en), 32'(exp_push));
        if (exp_push) chk("write_data", 32'(write_data), 32'(d));

        if (r) begin
            model_q.delete();
            m_valid = 1'b0;
            m_uflow = 1'b0;
        end else begin
            if (p && !m_valid) m_uflow = 1'b1;
            if (honored) popped_q.push_back(model_q.pop_front());
            if (exp_push) model_q.push_back(d);
            // Any push or honored pop costs one cycle of invisible output.
            m_valid = (model_q.size() > 0) && !(exp_push || honored);
        end

        @(posedge write_clk);
        #1;
        chk("count", 32'(count), 32'(model_q.size()));
        chk("index", 32'(index), (model_q.size() > 0) ? 32'(model_q.size() - 1) : 32'd0);
        chk("full", 32'(full), 32'(model_q.size() == DEPTH));
        chk("empty", 32'(empty), 32'(model_q.size() == 0));
        chk("out_valid", 32'(out_valid), 32'(m_valid));
        chk("underflow_err", 32'(underflow_err), 32'(m_uflow));
        if (m_valid && out_valid) chk("read_data", 32'(read_data), 32'(model_q[0]));
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, '0, 1'b0, 1'b0);
    endtask

    initial begin
        in_valid   = 1'b0;
        in_data    = '0;
        pop        = 1'b0;
        fifo_reset = 1'b1;
        for (int i = 0; i < DEPTH; i++) mem[i] = '0;

        cycle(1'b0, '0, 1'b0, 1'b1);
        cycle(1'b1, 16'h1111, 1'b1, 1'b1);

        // Single push: SETTLE then visible.
        cycle(1'b1, 16'h00A0, 1'b0, 1'b0);
        idle(2);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(1);

        // Three back-to-back pushes, then spaced pops give A, B, C in order.
        popped_q.delete();
        cycle(1'b1, 16'hAAAA, 1'b0, 1'b0);
        cycle(1'b1, 16'hBBBB, 1'b0, 1'b0);
        cycle(1'b1, 16'hCCCC, 1'b0, 1'b0);
        idle(1);
        for (int i = 0; i < 3; i++) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            idle(1);
        end
        chk("pop_order_n", 32'(popped_q.size()), 32'd3);
        if (popped_q.size() == 3) begin
            chk("pop_order_0", 32'(popped_q[0]), 32'hAAAA);
            chk("pop_order_1", 32'(popped_q[1]), 32'hBBBB);
            chk("pop_order_2", 32'(popped_q[2]), 32'hCCCC);
        end

        // Fill to 64, then try a 65th push.
        for (int i = 0; i < DEPTH; i++) cycle(1'b1, 16'(16'h4000 + i), 1'b0, 1'b0);
        cycle(1'b1, 16'hDEAD, 1'b0, 1'b0);
        idle(1);
        chk("full_count", 32'(count), 32'd64);

        // Drain to 5, then simultaneous push and pop.
        while (model_q.size() > 5) begin
            cycle(1'b0, '0, 1'b1, 1'b0);
            idle(1);
        end
        idle(1);
        cycle(1'b1, 16'h5555, 1'b1, 1'b0);
        chk("pushpop_cnt", 32'(count), 32'd5);
        idle(2);

        // Reset mid-operation, then pop in EMPTY sets sticky underflow.
        for (int i = 0; i < 5; i++) cycle(1'b1, 16'(16'h6000 + i), 1'b0, 1'b0);
        chk("pre_reset_cnt", 32'(count), 32'd10);
        cycle(1'b1, 16'hBEEF, 1'b0, 1'b1);
        cycle(1'b0, '0, 1'b1, 1'b0);
        idle(3);
        chk("uflow_sticky", 32'(underflow_err), 32'd1);
        cycle(1'b0, '0, 1'b0, 1'b1);

        // Random traffic with slow phases of fill bias and drain bias.
        for (int i = 0; i < 3000; i++) begin
            int phase;
            logic v, p, r;
            phase = (i / 400) % 3;
            v = ($urandom_range(99) < ((phase == 0) ? 85 : (phase == 1) ? 20 : 50));
            p = ($urandom_range(99) < ((phase == 0) ? 15 : (phase == 1) ? 80 : 50));
            r = ($urandom_range(999) < 3);
            cycle(v, 16'($urandom), p, r);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
